reg_file_sb: RTL

Parametrised integer register file with a configurable number of read ports, hardwired-zero register 0, same-cycle write-to-read bypass and an integrated pending-write scoreboard. It sits in the decode/writeback boundary of the pipeline. Decode issues reads and allocates destination registers. Writeback retires results. Hazard logic consumes the per-port busy flags to stall.

---
 rtl/reg_file_sb_if.sv | 31 +++
 rtl/reg_file_sb.sv | 79 +++++++
 2 files changed

// File: rtl/reg_file_sb_if.sv
// Read, writeback and allocate bus of the scoreboarded register file.
// Decode/writeback/hazard logic holds the master side, the register file the slave side.
interface reg_file_sb_if #(
    parameter int  DataWidth    = 32,
    parameter int  NumRegs      = 32,
    parameter int  NumReadPorts = 2,
    localparam int AddrWidth    = $clog2(NumRegs)
);
    logic [NumReadPorts-1:0]                rd_valid_i;
    logic [NumReadPorts-1:0][AddrWidth-1:0] rd_addr_i;
    logic [NumReadPorts-1:0][DataWidth-1:0] rd_data_o;
    logic [NumReadPorts-1:0]                rd_busy_o;
    logic                                   wr_valid_i;
    logic [AddrWidth-1:0]                   wr_addr_i;
    logic [DataWidth-1:0]                   wr_data_i;
    logic                                   alloc_valid_i;
    logic [AddrWidth-1:0]                   alloc_addr_i;
    logic [AddrWidth:0]                     pending_cnt_o;

    modport master (
        output rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               alloc_valid_i, alloc_addr_i,
        input  rd_data_o, rd_busy_o, pending_cnt_o
    );

    modport slave (
        input  rd_valid_i, rd_addr_i, wr_valid_i, wr_addr_i, wr_data_i,
               alloc_valid_i, alloc_addr_i,
        output rd_data_o, rd_busy_o, pending_cnt_o
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with r0 hardwired to zero, write-to-read bypass
// and a pending-write scoreboard with a running popcount.
module reg_file_sb #(
    parameter int  DataWidth    = 32,
    parameter int  NumRegs      = 32,
    parameter int  NumReadPorts = 2,
    localparam int AddrWidth    = $clog2(NumRegs)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    reg_file_sb_if.slave  bus
);
    localparam logic [AddrWidth:0] CntOne = 1;

    logic [DataWidth-1:0]                   mem_q [1:NumRegs-1];
    logic [DataWidth-1:0]                   mem_d [1:NumRegs-1];
    logic [NumRegs-1:0]                     pending_q, pending_d;
    logic [AddrWidth:0]                     cnt_q, cnt_d;
    logic [NumReadPorts-1:0][DataWidth-1:0] rd_data_q, rd_data_d;
    logic [NumReadPorts-1:0]                rd_busy_q, rd_busy_d;

    logic wr_en, alloc_en, alloc_set, wr_clr;

    always_comb begin
        wr_en     = bus.wr_valid_i && (bus.wr_addr_i != '0);
        alloc_en  = bus.alloc_valid_i && (bus.alloc_addr_i != '0);
        // Alloc wins over a same-register retire, so that retire clears nothing.
        alloc_set = alloc_en && !pending_q[bus.alloc_addr_i];
        wr_clr    = wr_en && pending_q[bus.wr_addr_i] &&
                    !(alloc_en && (bus.alloc_addr_i == bus.wr_addr_i));

        mem_d     = mem_q;
        pending_d = pending_q;
        if (wr_en) begin
            mem_d[bus.wr_addr_i]     = bus.wr_data_i;
            pending_d[bus.wr_addr_i] = 1'b0;
        end
        if (alloc_en) pending_d[bus.alloc_addr_i] = 1'b1;

        cnt_d = cnt_q;
        if (alloc_set && !wr_clr)      cnt_d = cnt_q + CntOne;
        else if (wr_clr && !alloc_set) cnt_d = cnt_q - CntOne;

        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        for (int p = 0; p < NumReadPorts; p++) begin
            if (bus.rd_valid_i[p]) begin
                if (bus.rd_addr_i[p] == '0)
                    rd_data_d[p] = '0;
                else if (bus.wr_valid_i && (bus.wr_addr_i == bus.rd_addr_i[p]))
                    rd_data_d[p] = bus.wr_data_i;
                else
                    rd_data_d[p] = mem_q[bus.rd_addr_i[p]];
                // Busy reflects this edge's write and alloc already applied.
                rd_busy_d[p] = pending_d[bus.rd_addr_i[p]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 1; i < NumRegs; i++) mem_q[i] <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            mem_q     <= mem_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data_o     = rd_data_q;
    assign bus.rd_busy_o     = rd_busy_q;
    assign bus.pending_cnt_o = cnt_q;
endmodule
